// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit check for the BCD add/sub sequencer
package bcd_pkg;
    localparam int DW = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, PASS1, FIX, DONE} state_t;
    function automatic logic is_bcd(input logic [DW-1:0] n);
        return n <= 4'd9;
    endfunction
endpackage

// File: rtl/bcd_addsub_seq_if.sv
// bcd_addsub_seq_if: host-side start/done handshake, operands and result fields
interface bcd_addsub_seq_if import bcd_pkg::*; #(parameter int NDIG = 8);
    logic start, op, busy, done, cout, neg, err;
    logic [DW*NDIG-1:0] a, b, result;
    modport master (output start, op, a, b, input busy, done, result, cout, neg, err);
    modport slave (input start, op, a, b, output busy, done, result, cout, neg, err);
endinterface

// File: rtl/bcd2_slice.sv
// bcd2_slice: combinational 2-digit BCD adder; M=1 nine's-complements B first
module bcd2_slice (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    input  logic       M,
    output logic [7:0] F,
    output logic       COUT
);
    logic [3:0] b0, b1;
    logic [4:0] s0, s1;
    logic       c0;
    always_comb begin
        b0 = M ? 4'd9 - B[3:0] : B[3:0];
        b1 = M ? 4'd9 - B[7:4] : B[7:4];
        s0 = 5'(A[3:0]) + 5'(b0) + 5'(CIN);
        c0 = s0 > 5'd9;
        s1 = 5'(A[7:4]) + 5'(b1) + 5'(c0);
        COUT = s1 > 5'd9;
        // subtracting 10 from a 4-bit digit is the same as adding 6 modulo 16
        F = {COUT ? s1[3:0] + 4'd6 : s1[3:0], c0 ? s0[3:0] + 4'd6 : s0[3:0]};
    end
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: runs one shared 2-digit BCD slice over NDIG digits, LS pair first;
// a borrowing subtract takes a second pass to turn the ten's complement into a magnitude.
module bcd_addsub_seq import bcd_pkg::*; #(parameter int NDIG = 8) (
    input logic clk,
    input logic rst,
    bcd_addsub_seq_if.slave bus
);
    localparam int P = NDIG / 2;
    localparam int IW = P > 1 ? $clog2(P) : 1;
    localparam int W = DW * NDIG;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, op_q, op_d, cout_q, cout_d, neg_q, neg_d, err_q, err_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
    logic bad, last, s_m, s_cout;
    logic [7:0] s_a, s_b, s_f;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            bad = bad | !is_bcd(bus.a[DW*i +: DW]) | !is_bcd(bus.b[DW*i +: DW]);
    end
    assign last = idx_q == IW'(P - 1);
    // FIX computes 0 - R as 0 + (99..9 - R) + 1 across all pairs
    assign s_a = state_q == FIX ? 8'h00 : a_q[{idx_q, 3'b000} +: 8];
    assign s_b = state_q == FIX ? work_q[{idx_q, 3'b000} +: 8] : b_q[{idx_q, 3'b000} +: 8];
    assign s_m = state_q == FIX ? OP_SUB : op_q;
    bcd2_slice u_slice (.A(s_a), .B(s_b), .CIN(carry_q), .M(s_m), .F(s_f), .COUT(s_cout));
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        carry_d = carry_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        work_d = work_q;
        result_d = result_q;
        cout_d = cout_q;
        neg_d = neg_q;
        err_d = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start && bad) begin
                    state_d = DONE;
                    result_d = '0;
                    cout_d = 1'b0;
                    neg_d = 1'b0;
                    err_d = 1'b1;
                end else if (bus.start) begin
                    state_d = PASS1;
                    a_d = bus.a;
                    b_d = bus.b;
                    op_d = bus.op;
                    idx_d = '0;
                    carry_d = bus.op;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                work_d[{idx_q, 3'b000} +: 8] = s_f;
                carry_d = s_cout;
                idx_d = idx_q + 1'b1;
                if (last && state_q == PASS1 && op_q == OP_SUB && !s_cout) begin
                    state_d = FIX;
                    idx_d = '0;
                    carry_d = 1'b1;
                end else if (last) begin
                    state_d = DONE;
                    result_d = work_d;
                    cout_d = state_q == PASS1 && op_q == OP_ADD && s_cout;
                    neg_d = state_q == FIX;
                    err_d = 1'b0;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            carry_q <= 1'b0;
            op_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            work_q <= '0;
            result_q <= '0;
            cout_q <= 1'b0;
            neg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            carry_q <= carry_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            work_q <= work_d;
            result_q <= result_d;
            cout_q <= cout_d;
            neg_q <= neg_d;
            err_q <= err_d;
        end
    end
    assign bus.busy = state_q == PASS1 || state_q == FIX;
    assign bus.done = state_q == DONE;
    assign bus.result = result_q;
    assign bus.cout = cout_q;
    assign bus.neg = neg_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: directed and random operations checked against an integer-arithmetic model
module tb_bcd_addsub_seq;
    localparam int NDIG = 8;
    localparam int W = 4 * NDIG;
    localparam longint unsigned MOD = 64'd100000000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    bcd_addsub_seq_if #(.NDIG(NDIG)) bus ();
    bcd_addsub_seq #(.NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned b2i(input logic [W-1:0] v);
        longint unsigned r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] i2b(input longint unsigned n);
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #1 bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // call just after an edge; reports the cycle of done counted from the start edge
    task automatic wait_done(input int offset, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = offset + k;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned ia, ib;
        logic [W-1:0] er;
        logic ec, en, ee;
        int el, lat, bc;
        ia = b2i(x);
        ib = b2i(y);
        ee = has_bad(x) || has_bad(y);
        ec = 1'b0;
        en = 1'b0;
        if (ee) begin
            er = '0;
            el = 1;
        end else if (o == 1'b0) begin
            er = i2b((ia + ib) % MOD);
            ec = (ia + ib) >= MOD;
            el = NDIG / 2 + 1;
        end else begin
            en = ia < ib;
            er = i2b(en ? ib - ia : ia - ib);
            el = en ? NDIG + 1 : NDIG / 2 + 1;
        end
        launch(o, x, y);
        wait_done(0, lat, bc);
        chk({tag, ".lat"}, W'(lat), W'(el));
        if (lat < 0) return;
        chk({tag, ".busy"}, W'(bc), W'(el - 1));
        chk({tag, ".res"}, bus.result, er);
        chk({tag, ".cout"}, W'(bus.cout), W'(ec));
        chk({tag, ".neg"}, W'(bus.neg), W'(en));
        chk({tag, ".err"}, W'(bus.err), W'(ee));
        @(negedge clk);
        chk({tag, ".pulse"}, W'(bus.done), '0);
        chk({tag, ".hold"}, bus.result, er);
    endtask

    initial begin
        logic [W-1:0] x, y;
        int lat, bc, dn;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        chk("rst.busy", W'(bus.busy), '0);
        chk("rst.done", W'(bus.done), '0);
        chk("rst.res", bus.result, '0);
        chk("rst.flags", W'({bus.cout, bus.neg, bus.err}), '0);
        @(negedge clk) rst = 1'b0;

        do_op("add1", 1'b0, 32'h00005555, 32'h00009999);
        do_op("addovf", 1'b0, 32'h99999999, 32'h00000001);
        do_op("sub1", 1'b1, 32'h00005555, 32'h00003333);
        do_op("subeq", 1'b1, 32'h00001234, 32'h00001234);
        do_op("subneg", 1'b1, 32'h00001111, 32'h00005555);
        do_op("errA", 1'b0, 32'h0000000A, 32'h00000001);
        do_op("clrerr", 1'b0, 32'h00000012, 32'h00000034);
        do_op("errB", 1'b1, 32'h00000001, 32'hF0000000);
        do_op("subbig", 1'b1, 32'h00000000, 32'h99999999);

        // a second start while busy must be ignored
        launch(1'b0, 32'h12345678, 32'h11111111);
        @(posedge clk);
        #1 bus.start = 1'b1; bus.a = 32'h99999999; bus.b = 32'h99999999; bus.op = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(2, lat, bc);
        chk("ign.lat", W'(lat), W'(5));
        chk("ign.res", bus.result, 32'h23456789);
        chk("ign.neg", W'(bus.neg), '0);

        // async reset mid-operation
        launch(1'b1, 32'h00001111, 32'h00005555);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.busy", W'(bus.busy), '0);
        chk("arst.done", W'(bus.done), '0);
        chk("arst.res", bus.result, '0);
        chk("arst.flags", W'({bus.cout, bus.neg, bus.err}), '0);
        @(negedge clk) rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("arst.quiet", W'(dn), '0);
        do_op("post", 1'b0, 32'h00004321, 32'h00001234);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                x[4*i +: 4] = 4'($urandom_range(0, 9));
                y[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) x[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) y[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) y = x;
            if ($urandom_range(0, 3) == 0) y = y >> (4 * $urandom_range(1, NDIG - 1));
            do_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), x, y);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
